// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX slot I/O bus and the I/O router built on it.
package msx_bus_pkg;

    localparam int IO_ADDR_W = 8;
    localparam int DATA_W    = 8;

    localparam logic [DATA_W-1:0] FF_DATA_DEF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2
    } router_state_t;

    // Width of a device index; a single device still needs one bit.
    function automatic int sel_width(input int num_dev);
        return (num_dev > 1) ? $clog2(num_dev) : 1;
    endfunction

endpackage

// File: rtl/msx_io_decode.sv
// Combinational I/O address decoder: per-device base/mask match with lowest-index priority.
module msx_io_decode
    import msx_bus_pkg::*;
#(
    parameter int                            NUM_DEV   = 4,
    parameter logic [NUM_DEV*IO_ADDR_W-1:0]  BASE_ADDR = {8'hE8, 8'hA8, 8'hA0, 8'h98},
    parameter logic [NUM_DEV*IO_ADDR_W-1:0]  ADDR_MASK = {8'hFE, 8'hFC, 8'hFC, 8'hFC},
    parameter int                            SEL_W     = sel_width(NUM_DEV)
) (
    input  logic [IO_ADDR_W-1:0] addr,
    output logic                 hit,
    output logic [SEL_W-1:0]     sel
);

    logic [NUM_DEV-1:0] hit_vec_s;

    // Per-device compare of the I/O address against its base under its mask.
    always_comb begin
        hit_vec_s = {NUM_DEV{1'b0}};
        for (int i = 0; i < NUM_DEV; i++) begin
            hit_vec_s[i] = ((addr ^ BASE_ADDR[IO_ADDR_W*i +: IO_ADDR_W])
                            & ADDR_MASK[IO_ADDR_W*i +: IO_ADDR_W]) == {IO_ADDR_W{1'b0}};
        end
    end

    // Priority encode; scanning downwards leaves the lowest matching index in sel.
    always_comb begin
        hit = |hit_vec_s;
        sel = {SEL_W{1'b0}};
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            sel = hit_vec_s[i] ? SEL_W'(i) : sel;
        end
    end

endmodule

// File: rtl/msx_io_router.sv
// I/O router from the msx_slot bus to NUM_DEV peripherals: one transaction in flight,
// ready back-pressure, read-data steering and a stalled-device timeout.
module msx_io_router
    import msx_bus_pkg::*;
#(
    parameter int                            NUM_DEV   = 4,
    parameter logic [NUM_DEV*IO_ADDR_W-1:0]  BASE_ADDR = {8'hE8, 8'hA8, 8'hA0, 8'h98},
    parameter logic [NUM_DEV*IO_ADDR_W-1:0]  ADDR_MASK = {8'hFE, 8'hFC, 8'hFC, 8'hFC},
    parameter int                            TIMEOUT   = 255,
    parameter logic [DATA_W-1:0]             FF_DATA   = FF_DATA_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [15:0]                 bus_address,
    input  logic                        bus_ioreq,
    input  logic                        bus_write,
    input  logic                        bus_valid,
    output logic                        bus_ready,
    input  logic [DATA_W-1:0]           bus_wdata,
    output logic [DATA_W-1:0]           bus_rdata,
    output logic                        bus_rdata_en,
    output logic [15:0]                 dev_address,
    output logic                        dev_write,
    output logic [DATA_W-1:0]           dev_wdata,
    output logic [NUM_DEV-1:0]          dev_valid,
    input  logic [NUM_DEV-1:0]          dev_ready,
    input  logic [NUM_DEV*DATA_W-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]          dev_rdata_en,
    output logic                        timeout_err
);

    localparam int         SEL_W   = sel_width(NUM_DEV);
    // Abort fires on the edge that ends the TIMEOUT-th cycle of dev_valid.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    router_state_t        state_r;
    logic [SEL_W-1:0]     sel_r;
    logic [7:0]           cnt_r;

    logic                 dec_hit_s;
    logic [SEL_W-1:0]     dec_sel_s;
    logic                 accept_s;
    logic                 timed_out_s;
    logic                 sel_ready_s;
    logic                 sel_strobe_s;
    logic [DATA_W-1:0]    sel_rdata_s;
    logic [NUM_DEV-1:0]   onehot_s;

    msx_io_decode #(
        .NUM_DEV   (NUM_DEV),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK),
        .SEL_W     (SEL_W)
    ) u_decode (
        .addr (bus_address[IO_ADDR_W-1:0]),
        .hit  (dec_hit_s),
        .sel  (dec_sel_s)
    );

    assign accept_s    = bus_valid & bus_ioreq & bus_ready & dec_hit_s & (state_r == ST_IDLE);
    assign timed_out_s = (cnt_r >= TO_LAST);

    // Steer the latched device's handshake and data, and one-hot the decoded index.
    always_comb begin
        sel_ready_s  = 1'b0;
        sel_strobe_s = 1'b0;
        sel_rdata_s  = {DATA_W{1'b0}};
        onehot_s     = {NUM_DEV{1'b0}};
        for (int i = 0; i < NUM_DEV; i++) begin
            sel_ready_s  = (sel_r == SEL_W'(i)) ? dev_ready[i]    : sel_ready_s;
            sel_strobe_s = (sel_r == SEL_W'(i)) ? dev_rdata_en[i] : sel_strobe_s;
            sel_rdata_s  = (sel_r == SEL_W'(i)) ? dev_rdata[DATA_W*i +: DATA_W] : sel_rdata_s;
            onehot_s[i]  = (dec_sel_s == SEL_W'(i));
        end
    end

    // Transaction FSM with latched request, timeout counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            sel_r        <= {SEL_W{1'b0}};
            cnt_r        <= 8'd0;
            bus_ready    <= 1'b1;
            bus_rdata    <= {DATA_W{1'b0}};
            bus_rdata_en <= 1'b0;
            dev_address  <= 16'h0000;
            dev_write    <= 1'b0;
            dev_wdata    <= {DATA_W{1'b0}};
            dev_valid    <= {NUM_DEV{1'b0}};
            timeout_err  <= 1'b0;
        end else begin
            bus_rdata_en <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // bus_ready rises one cycle after returning here, giving the 2-cycle write gap.
                    bus_ready <= 1'b1;
                    if (accept_s) begin
                        dev_address <= bus_address;
                        dev_write   <= bus_write;
                        dev_wdata   <= bus_wdata;
                        sel_r       <= dec_sel_s;
                        cnt_r       <= 8'd0;
                        dev_valid   <= onehot_s;
                        bus_ready   <= 1'b0;
                        state_r     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    bus_ready <= 1'b0;
                    if (sel_ready_s) begin
                        dev_valid <= {NUM_DEV{1'b0}};
                        cnt_r     <= cnt_r + 8'd1;
                        if (dev_write) begin
                            state_r <= ST_IDLE;
                        end else if (sel_strobe_s) begin
                            bus_rdata    <= sel_rdata_s;
                            bus_rdata_en <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            state_r <= ST_RDWAIT;
                        end
                    end else if (timed_out_s) begin
                        dev_valid   <= {NUM_DEV{1'b0}};
                        timeout_err <= 1'b1;
                        if (!dev_write) begin
                            bus_rdata    <= FF_DATA;
                            bus_rdata_en <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_RDWAIT: begin
                    bus_ready <= 1'b0;
                    if (sel_strobe_s) begin
                        bus_rdata    <= sel_rdata_s;
                        bus_rdata_en <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else if (timed_out_s) begin
                        timeout_err  <= 1'b1;
                        bus_rdata    <= FF_DATA;
                        bus_rdata_en <= 1'b1;
                        state_r      <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    dev_valid <= {NUM_DEV{1'b0}};
                    bus_ready <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msx_io_router.sv
// Directed bench for msx_io_router with a read-data scoreboard (2 devices, TIMEOUT=16).
module tb_msx_io_router;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bus_address;
    logic        bus_ioreq;
    logic        bus_write;
    logic        bus_valid;
    logic        bus_ready;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rdata_en;
    logic [15:0] dev_address;
    logic        dev_write;
    logic [7:0]  dev_wdata;
    logic [1:0]  dev_valid;
    logic [1:0]  dev_ready;
    logic [15:0] dev_rdata;
    logic [1:0]  dev_rdata_en;
    logic        timeout_err;

    int         checks = 0;
    int         errors = 0;
    int         rd_en_count = 0;
    int         to_count = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    msx_io_router #(
        .NUM_DEV   (2),
        .BASE_ADDR (16'hA098),
        .ADDR_MASK (16'hFEFC),
        .TIMEOUT   (16),
        .FF_DATA   (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_address  (bus_address),
        .bus_ioreq    (bus_ioreq),
        .bus_write    (bus_write),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_rdata_en (bus_rdata_en),
        .dev_address  (dev_address),
        .dev_write    (dev_write),
        .dev_wdata    (dev_wdata),
        .dev_valid    (dev_valid),
        .dev_ready    (dev_ready),
        .dev_rdata    (dev_rdata),
        .dev_rdata_en (dev_rdata_en),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every read-data strobe must match the oldest expected read.
    always @(negedge clk) begin
        if (bus_rdata_en === 1'b1) begin
            rd_en_count++;
            chk("rdata_en_expected", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) chk("sb_rdata", bus_rdata, sb_q.pop_front());
        end
        if (timeout_err === 1'b1) to_count++;
    end

    initial begin
        int n;
        int rd0;
        int to0;

        reset = 1'b1; bus_address = 16'h0000; bus_ioreq = 1'b0; bus_write = 1'b0;
        bus_valid = 1'b0; bus_wdata = 8'h00; dev_ready = 2'b00; dev_rdata = 16'h0000;
        dev_rdata_en = 2'b00;
        repeat (3) tick();
        chk("rst_bus_ready", bus_ready, 1);
        chk("rst_bus_rdata", bus_rdata, 0);
        chk("rst_bus_rdata_en", bus_rdata_en, 0);
        chk("rst_dev_valid", dev_valid, 0);
        chk("rst_dev_address", dev_address, 0);
        chk("rst_dev_write", dev_write, 0);
        chk("rst_dev_wdata", dev_wdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        tick();

        // 1: write 0x99 <= 0x5A, dev0 ready in the first dev_valid cycle
        bus_valid = 1'b1; bus_ioreq = 1'b1; bus_write = 1'b1; bus_address = 16'h0099; bus_wdata = 8'h5A;
        tick();
        bus_valid = 1'b0; dev_ready = 2'b01;
        chk("t1_dev_valid", dev_valid, 2'b01);
        chk("t1_dev_address", dev_address, 16'h0099);
        chk("t1_dev_wdata", dev_wdata, 8'h5A);
        chk("t1_dev_write", dev_write, 1);
        chk("t1_ready_low1", bus_ready, 0);
        tick();
        dev_ready = 2'b00;
        chk("t1_dev_valid_drop", dev_valid, 2'b00);
        chk("t1_ready_low2", bus_ready, 0);
        tick();
        chk("t1_ready_back", bus_ready, 1);

        // 2: read 0xA1, dev1 answers two cycles into the request; dev0 strobe ignored
        rd0 = rd_en_count;
        bus_valid = 1'b1; bus_write = 1'b0; bus_address = 16'h00A1;
        sb_q.push_back(8'h3C);
        tick();
        bus_valid = 1'b0;
        chk("t2_dev_valid", dev_valid, 2'b10);
        dev_rdata = 16'h3C77; dev_rdata_en = 2'b01;
        tick();
        chk("t2_dev_valid_held", dev_valid, 2'b10);
        dev_rdata_en = 2'b10; dev_ready = 2'b10;
        tick();
        dev_rdata_en = 2'b00; dev_ready = 2'b00;
        chk("t2_dev_valid_drop", dev_valid, 2'b00);
        chk("t2_rdata", bus_rdata, 8'h3C);
        tick();
        tick();
        chk("t2_one_strobe", rd_en_count - rd0, 1);
        chk("t2_ready_back", bus_ready, 1);

        // 3: read 0x40 hits nothing
        rd0 = rd_en_count;
        bus_valid = 1'b1; bus_address = 16'h0040;
        tick();
        bus_valid = 1'b0;
        chk("t3_dev_valid", dev_valid, 2'b00);
        chk("t3_ready", bus_ready, 1);
        repeat (3) tick();
        chk("t3_no_strobe", rd_en_count - rd0, 0);

        // 4: read 0x98, dev0 never ready -> timeout with FF data
        bus_valid = 1'b1; bus_address = 16'h0098;
        sb_q.push_back(8'hFF);
        tick();
        bus_valid = 1'b0;
        chk("t4_dev_valid", dev_valid, 2'b01);
        n = 0;
        while (timeout_err !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("t4_timeout_cycles", n, 16);
        chk("t4_dev_valid_drop", dev_valid, 2'b00);
        chk("t4_rdata_ff", bus_rdata, 8'hFF);
        chk("t4_rdata_en", bus_rdata_en, 1);
        tick();
        chk("t4_err_pulse", timeout_err, 0);
        tick();
        chk("t4_ready_back", bus_ready, 1);

        // 5: reset while waiting for read data, then a late strobe
        rd0 = rd_en_count; to0 = to_count;
        bus_valid = 1'b1; bus_address = 16'h0098;
        tick();
        bus_valid = 1'b0; dev_ready = 2'b01;
        tick();
        dev_ready = 2'b00; reset = 1'b1;
        chk("t5_in_rdwait_valid", dev_valid, 2'b00);
        tick();
        reset = 1'b0; dev_rdata = 16'h0055; dev_rdata_en = 2'b01;
        tick();
        dev_rdata_en = 2'b00;
        repeat (20) tick();
        chk("t5_ready", bus_ready, 1);
        chk("t5_rdata", bus_rdata, 0);
        chk("t5_no_strobe", rd_en_count - rd0, 0);
        chk("t5_no_timeout", to_count - to0, 0);

        // 6: memory request ignored; request while busy ignored
        bus_valid = 1'b1; bus_ioreq = 1'b0; bus_address = 16'h0098;
        tick();
        bus_valid = 1'b0; bus_ioreq = 1'b1;
        chk("t6_mem_dev_valid", dev_valid, 2'b00);
        chk("t6_mem_ready", bus_ready, 1);
        bus_valid = 1'b1; bus_write = 1'b1; bus_address = 16'h009A; bus_wdata = 8'h11;
        tick();
        bus_address = 16'h00A0; bus_wdata = 8'h22;
        chk("t6_first_valid", dev_valid, 2'b01);
        tick();
        chk("t6_busy_valid", dev_valid, 2'b01);
        chk("t6_busy_addr", dev_address, 16'h009A);
        dev_ready = 2'b01;
        tick();
        bus_valid = 1'b0; dev_ready = 2'b00;
        chk("t6_done_valid", dev_valid, 2'b00);
        chk("t6_wdata", dev_wdata, 8'h11);
        repeat (2) tick();
        chk("t6_idle_valid", dev_valid, 2'b00);
        chk("t6_idle_ready", bus_ready, 1);

        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
